// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch and jump control ahead of the 8-bit program counter
// Two-phase FETCH/EXEC sequencer with a HALT sink; owns the instruction and flags registers.

module fetch_sequencer #(
    parameter logic [7:0] RESET_VEC  = 8'h00,
    parameter logic [3:0] JMP_CLASS  = 4'hF,
    parameter logic [3:0] HALT_CLASS = 4'hE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pc,
    input  logic [15:0] rom_data,
    input  logic [3:0]  alu_flags,
    output logic        PCincr,
    output logic [7:0]  pc_data,
    output logic [15:0] ir,
    output logic        exec,
    output logic [3:0]  flags,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0] ins_class;
    logic [3:0] ins_cond;
    logic [7:0] ins_target;
    logic       is_jump;
    logic       is_halt;
    logic       is_nop;
    logic       jump_taken;
    logic       load_ir;
    logic       load_flags;

    assign ins_class  = ir[15:12];
    assign ins_cond   = ir[11:8];
    assign ins_target = ir[7:0];
    assign is_jump    = (ins_class == JMP_CLASS);
    assign is_halt    = (ins_class == HALT_CLASS);
    assign is_nop     = (ins_class == 4'h0);

    // Conditions test the registered flags {Z,N,C,V}; codes 8-F never jump.
    always_comb begin
        jump_taken = 1'b0;
        case (ins_cond)
            4'h0:    jump_taken = 1'b1;
            4'h1:    jump_taken = flags[3];
            4'h2:    jump_taken = ~flags[3];
            4'h3:    jump_taken = flags[1];
            4'h4:    jump_taken = ~flags[1];
            4'h5:    jump_taken = flags[2];
            4'h6:    jump_taken = ~flags[2];
            4'h7:    jump_taken = flags[0];
            default: jump_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            ir    <= 16'h0000;
            flags <= 4'h0;
        end else begin
            state <= next_state;
            if (load_ir) begin
                ir <= rom_data;
            end
            if (load_flags) begin
                flags <= alu_flags;
            end
        end
    end

    always_comb begin
        next_state = state;
        PCincr     = 1'b0;
        pc_data    = ins_target;
        exec       = 1'b0;
        halted     = 1'b0;
        load_ir    = 1'b0;
        load_flags = 1'b0;

        case (state)
            ST_FETCH: begin
                // PC holds by reloading its own value while the ROM word is captured.
                pc_data    = pc;
                load_ir    = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                next_state = ST_FETCH;
                if (is_jump) begin
                    PCincr = ~jump_taken;
                end else if (is_halt) begin
                    pc_data    = pc;
                    next_state = ST_HALT;
                end else if (is_nop) begin
                    PCincr = 1'b1;
                end else begin
                    PCincr     = 1'b1;
                    exec       = 1'b1;
                    load_flags = 1'b1;
                end
            end
            ST_HALT: begin
                pc_data = pc;
                halted  = 1'b1;
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase

        // Reset forces the PC to the vector regardless of the current state.
        if (reset) begin
            PCincr     = 1'b0;
            pc_data    = RESET_VEC;
            exec       = 1'b0;
            halted     = 1'b0;
            load_ir    = 1'b0;
            load_flags = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer with an instruction-level model
// The bench owns the PC register and the ROM; expectations come from per-instruction semantics.

module tb_fetch_sequencer;

    localparam logic [7:0] RESET_VEC = 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pc = 8'h00;
    logic [15:0] rom_data;
    logic [3:0]  alu_flags = 4'h0;
    logic        PCincr;
    logic [7:0]  pc_data;
    logic [15:0] ir;
    logic        exec;
    logic [3:0]  flags;
    logic        halted;

    logic [15:0] rom [256];

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exec_cnt = 0;

    bit         af_rand = 1'b0;
    logic [3:0] af_fixed = 4'h0;

    // Instruction-level model: where the program is, what it has committed.
    logic [7:0]  m_pc = 8'h00;
    logic [15:0] m_ir = 16'h0000;
    logic [3:0]  m_flags = 4'h0;
    int          m_phase = 0;

    fetch_sequencer #(
        .RESET_VEC(RESET_VEC),
        .JMP_CLASS(4'hF),
        .HALT_CLASS(4'hE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .rom_data(rom_data),
        .alu_flags(alu_flags),
        .PCincr(PCincr),
        .pc_data(pc_data),
        .ir(ir),
        .exec(exec),
        .flags(flags),
        .halted(halted)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[pc];

    always @(posedge clk) begin
        pc <= PCincr ? pc + 8'd1 : pc_data;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        // f is {Z,N,C,V}
        case (c)
            4'h0: return 1'b1;
            4'h1: return f[3];
            4'h2: return !f[3];
            4'h3: return f[1];
            4'h4: return !f[1];
            4'h5: return f[2];
            4'h6: return !f[2];
            4'h7: return f[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic cycle(input bit rst);
        logic [3:0] af;
        logic [3:0] cls;
        logic [7:0] npc;
        bit         to_halt;
        bit         alu_op;
        @(negedge clk);
        reset = rst;
        af = af_rand ? 4'($urandom) : af_fixed;
        alu_flags = af;
        #1;
        cls = m_ir[15:12];
        npc = m_pc;
        to_halt = 1'b0;
        alu_op = 1'b0;
        if (rst) begin
            check("rst_pcincr", 16'(PCincr), 16'(0));
            check("rst_pc_data", 16'(pc_data), 16'(RESET_VEC));
            check("rst_exec", 16'(exec), 16'(0));
            check("rst_halted", 16'(halted), 16'(0));
        end else if (m_phase == 0) begin
            check("fetch_pcincr", 16'(PCincr), 16'(0));
            check("fetch_pc_data", 16'(pc_data), 16'(m_pc));
            check("fetch_exec", 16'(exec), 16'(0));
            check("fetch_halted", 16'(halted), 16'(0));
        end else if (m_phase == 1) begin
            if (cls == 4'hF) begin
                npc = cond_holds(m_ir[11:8], m_flags) ? m_ir[7:0] : m_pc + 8'd1;
            end else if (cls == 4'hE) begin
                to_halt = 1'b1;
            end else begin
                npc = m_pc + 8'd1;
                alu_op = (cls != 4'h0);
            end
            check("exec_exec", 16'(exec), 16'(alu_op));
            check("exec_halted", 16'(halted), 16'(0));
            check("exec_next_pc", 16'(PCincr ? pc + 8'd1 : pc_data), 16'(npc));
        end else begin
            check("halt_pcincr", 16'(PCincr), 16'(0));
            check("halt_pc_data", 16'(pc_data), 16'(m_pc));
            check("halt_halted", 16'(halted), 16'(1));
            check("halt_exec", 16'(exec), 16'(0));
        end
        if (exec === 1'b1) exec_cnt++;

        if (rst) begin
            m_pc = RESET_VEC;
            m_ir = 16'h0000;
            m_flags = 4'h0;
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_ir = rom[m_pc];
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_pc = npc;
            if (alu_op) m_flags = af;
            m_phase = to_halt ? 2 : 0;
        end

        @(posedge clk);
        #1;
        check("pc", 16'(pc), 16'(m_pc));
        check("ir", ir, m_ir);
        check("flags", 16'(flags), 16'(m_flags));
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        cycle(1'b1);
        cycle(1'b1);
    endtask

    initial begin
        clear_rom();

        // Reset, then plain NOP stepping.
        af_rand = 1'b0;
        af_fixed = 4'h0;
        do_reset();
        check("reset_pc", 16'(pc), 16'(RESET_VEC));
        for (int i = 0; i < 8; i++) cycle(1'b0);
        check("nop_pc_after_4", 16'(pc), 16'(4));

        // ALU sets Z, then JZ taken.
        rom[0] = 16'h1000;
        rom[1] = 16'hF140;
        af_fixed = 4'b1000;
        do_reset();
        exec_cnt = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0);
        check("jz_taken_pc", 16'(pc), 16'h40);
        check("jz_flags", 16'(flags), 16'h8);
        check("alu_exec_once", 16'(exec_cnt), 16'(1));

        // Same program with Z clear: falls through.
        af_fixed = 4'b0000;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0);
        check("jz_not_taken_pc", 16'(pc), 16'h02);

        // Undefined condition never jumps.
        rom[0] = 16'hF9FF;
        do_reset();
        cycle(1'b0);
        cycle(1'b0);
        check("undef_cond_pc", 16'(pc), 16'h01);

        // Halt at address 5 holds the PC.
        clear_rom();
        rom[5] = 16'hE000;
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b0);
        check("halt_entered", 16'(halted), 16'(1));
        for (int i = 0; i < 20; i++) cycle(1'b0);
        check("halt_pc_held", 16'(pc), 16'h05);
        check("halt_ir_held", ir, 16'hE000);
        cycle(1'b1);
        check("halt_left_on_reset", 16'(pc), 16'(RESET_VEC));

        // Reset arriving during EXEC of a taken jump.
        clear_rom();
        rom[0] = 16'h1000;
        rom[1] = 16'hF040;
        af_fixed = 4'hF;
        do_reset();
        cycle(1'b0);
        cycle(1'b0);
        check("pre_jump_flags", 16'(flags), 16'hF);
        cycle(1'b0);
        cycle(1'b1);
        check("jump_reset_pc", 16'(pc), 16'(RESET_VEC));
        check("jump_reset_flags", 16'(flags), 16'h0);

        // Random programs, random ALU flags, occasional reset.
        for (int i = 0; i < 256; i++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 3) rom[i] = {4'h0, 12'($urandom)};
            else if (r < 8) rom[i] = {4'hF, 12'($urandom)};
            else if ($urandom_range(0, 63) == 0) rom[i] = 16'hE000;
            else rom[i] = {4'($urandom_range(1, 13)), 12'($urandom)};
        end
        af_rand = 1'b1;
        do_reset();
        for (int i = 0; i < 4000; i++) cycle($urandom_range(0, 199) == 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
